// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 register file: B-bus selects, C-enable
// and memory-op bit positions, and reset defaults.
package mic1_pkg;

    typedef enum logic [3:0] {
        B_MDR    = 4'd0,
        B_PC     = 4'd1,
        B_MBR_SX = 4'd2,
        B_MBR_ZX = 4'd3,
        B_SP     = 4'd4,
        B_LV     = 4'd5,
        B_CPP    = 4'd6,
        B_TOS    = 4'd7,
        B_OPC    = 4'd8
    } b_sel_e;

    localparam int unsigned C_EN_MAR = 0;
    localparam int unsigned C_EN_MDR = 1;
    localparam int unsigned C_EN_PC  = 2;
    localparam int unsigned C_EN_SP  = 3;
    localparam int unsigned C_EN_LV  = 4;
    localparam int unsigned C_EN_CPP = 5;
    localparam int unsigned C_EN_TOS = 6;
    localparam int unsigned C_EN_OPC = 7;
    localparam int unsigned C_EN_H   = 8;

    localparam int unsigned MEM_FETCH = 0;
    localparam int unsigned MEM_RD    = 1;
    localparam int unsigned MEM_WR    = 2;

    localparam logic [31:0] DEF_RESET_SP  = 32'h0000_4000;
    localparam logic [31:0] DEF_RESET_LV  = 32'h0000_3000;
    localparam logic [31:0] DEF_RESET_CPP = 32'h0000_1000;

endpackage

// File: rtl/mic1_mem_port.sv
// One-outstanding-request memory port: strobe, pending flag, registered
// address/write data, and the stall term raised while a request is still open.
module mic1_mem_port #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic              hold,
    input  logic              ack,
    input  logic [ADDR_W-1:0] addr_next,
    input  logic [DATA_W-1:0] wdata_next,
    output logic              rd,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              read_done,
    output logic              stall_term
);

    logic pend;
    logic pend_rd;
    logic req;
    logic issue;

    assign req        = req_rd | req_wr;
    assign issue      = req & ~hold;
    assign stall_term = req & pend & ~ack;
    // Only a pending read returns data; an ack with nothing open is dropped.
    assign read_done  = ack & pend & pend_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            pend_rd <= 1'b0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
        end else begin
            rd <= issue & req_rd;
            wr <= issue & req_wr;
            if (issue) begin
                pend    <= 1'b1;
                pend_rd <= req_rd;
                addr    <= addr_next;
                wdata   <= wdata_next;
            end else if (ack) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mic1_regfile.sv
// MIC-1 datapath register file: C-bus write-back, B-bus/H operands and the
// MAR/MDR data port plus PC/MBR fetch port with controller stall.
module mic1_regfile
    import mic1_pkg::*;
#(
    parameter logic [31:0] RESET_SP  = DEF_RESET_SP,
    parameter logic [31:0] RESET_LV  = DEF_RESET_LV,
    parameter logic [31:0] RESET_CPP = DEF_RESET_CPP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] c_bus,
    input  logic [8:0]  c_en,
    input  logic [3:0]  b_sel,
    input  logic [2:0]  mem_op,
    output logic [31:0] b_bus,
    output logic [31:0] h_out,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] fetch_addr,
    output logic        fetch_req,
    input  logic        fetch_valid,
    input  logic [7:0]  fetch_data,
    output logic        stall
);

    logic [31:0] h, opc, tos, cpp, lv, sp, pc, mdr, mar;
    logic [7:0]  mbr;
    logic [31:0] h_n, opc_n, tos_n, cpp_n, lv_n, sp_n, pc_n, mdr_n, mar_n;
    logic [7:0]  mbr_n;

    logic        data_stall;
    logic        fetch_stall;
    logic        illegal;
    logic        data_done;
    logic        fetch_done;
    logic        c_ok;
    logic        fetch_wr_unused;
    logic        fetch_wdata_unused;
    b_sel_e      sel;

    assign illegal = mem_op[MEM_WR] & mem_op[MEM_RD];
    assign stall   = data_stall | fetch_stall | illegal;
    assign c_ok    = ~stall;

    // Post-edge register values; the ports latch these so a same-cycle
    // C write to MAR/MDR/PC is what goes out on the bus.
    always_comb begin
        h_n   = h;
        opc_n = opc;
        tos_n = tos;
        cpp_n = cpp;
        lv_n  = lv;
        sp_n  = sp;
        pc_n  = pc;
        mdr_n = mdr;
        mar_n = mar;
        mbr_n = mbr;
        if (c_ok) begin
            if (c_en[C_EN_H])   h_n   = c_bus;
            if (c_en[C_EN_OPC]) opc_n = c_bus;
            if (c_en[C_EN_TOS]) tos_n = c_bus;
            if (c_en[C_EN_CPP]) cpp_n = c_bus;
            if (c_en[C_EN_LV])  lv_n  = c_bus;
            if (c_en[C_EN_SP])  sp_n  = c_bus;
            if (c_en[C_EN_PC])  pc_n  = c_bus;
            if (c_en[C_EN_MDR]) mdr_n = c_bus;
            if (c_en[C_EN_MAR]) mar_n = c_bus;
        end
        if (data_done)  mdr_n = mem_rdata;
        if (fetch_done) mbr_n = fetch_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h   <= '0;
            opc <= '0;
            tos <= '0;
            cpp <= RESET_CPP;
            lv  <= RESET_LV;
            sp  <= RESET_SP;
            pc  <= '0;
            mdr <= '0;
            mar <= '0;
            mbr <= '0;
        end else begin
            h   <= h_n;
            opc <= opc_n;
            tos <= tos_n;
            cpp <= cpp_n;
            lv  <= lv_n;
            sp  <= sp_n;
            pc  <= pc_n;
            mdr <= mdr_n;
            mar <= mar_n;
            mbr <= mbr_n;
        end
    end

    assign sel = b_sel_e'(b_sel);

    always_comb begin
        b_bus = '0;
        case (sel)
            B_MDR:    b_bus = mdr;
            B_PC:     b_bus = pc;
            B_MBR_SX: b_bus = {{24{mbr[7]}}, mbr};
            B_MBR_ZX: b_bus = {24'h0, mbr};
            B_SP:     b_bus = sp;
            B_LV:     b_bus = lv;
            B_CPP:    b_bus = cpp;
            B_TOS:    b_bus = tos;
            B_OPC:    b_bus = opc;
            default:  b_bus = '0;
        endcase
    end

    assign h_out = h;

    mic1_mem_port #(
        .ADDR_W(32),
        .DATA_W(32)
    ) u_data_port (
        .clk        (clk),
        .rst        (rst),
        .req_rd     (mem_op[MEM_RD]),
        .req_wr     (mem_op[MEM_WR]),
        .hold       (stall),
        .ack        (mem_ack),
        .addr_next  (mar_n),
        .wdata_next (mdr_n),
        .rd         (mem_rd),
        .wr         (mem_wr),
        .addr       (mem_addr),
        .wdata      (mem_wdata),
        .read_done  (data_done),
        .stall_term (data_stall)
    );

    // The fetch port is read-only, so its write side stays idle.
    mic1_mem_port #(
        .ADDR_W(32),
        .DATA_W(1)
    ) u_fetch_port (
        .clk        (clk),
        .rst        (rst),
        .req_rd     (mem_op[MEM_FETCH]),
        .req_wr     (1'b0),
        .hold       (stall),
        .ack        (fetch_valid),
        .addr_next  (pc_n),
        .wdata_next (1'b0),
        .rd         (fetch_req),
        .wr         (fetch_wr_unused),
        .addr       (fetch_addr),
        .wdata      (fetch_wdata_unused),
        .read_done  (fetch_done),
        .stall_term (fetch_stall)
    );

endmodule

// File: tb/tb_mic1_regfile.sv
// Bench for mic1_regfile: directed scenarios then random traffic, all compared
// against a register/pending-flag reference model kept in the bench.
module tb_mic1_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] c_bus;
    logic [8:0]  c_en;
    logic [3:0]  b_sel;
    logic [2:0]  mem_op;
    logic [31:0] b_bus;
    logic [31:0] h_out;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] fetch_addr;
    logic        fetch_req;
    logic        fetch_valid;
    logic [7:0]  fetch_data;
    logic        stall;

    int checks = 0;
    int errors = 0;

    // Model: m_r index = c_en bit (0 MAR,1 MDR,2 PC,3 SP,4 LV,5 CPP,6 TOS,7 OPC,8 H)
    logic [31:0] m_r [0:8];
    logic [7:0]  m_mbr;
    logic        m_dpend, m_dread, m_fpend;
    logic        e_rd, e_wr, e_freq;
    logic [31:0] e_addr, e_wdata, e_faddr;

    mic1_regfile #(
        .RESET_SP (32'h0000_4000),
        .RESET_LV (32'h0000_3000),
        .RESET_CPP(32'h0000_1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .c_bus      (c_bus),
        .c_en       (c_en),
        .b_sel      (b_sel),
        .mem_op     (mem_op),
        .b_bus      (b_bus),
        .h_out      (h_out),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fetch_addr (fetch_addr),
        .fetch_req  (fetch_req),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_stall();
        logic data_req;
        data_req = mem_op[2] | mem_op[1];
        return (data_req & m_dpend & ~mem_ack) | (mem_op[0] & m_fpend & ~fetch_valid)
             | (mem_op[2] & mem_op[1]);
    endfunction

    function automatic logic [31:0] model_b(input logic [3:0] s);
        case (s)
            4'd0: return m_r[1];
            4'd1: return m_r[2];
            4'd2: return {{24{m_mbr[7]}}, m_mbr};
            4'd3: return {24'h0, m_mbr};
            4'd4: return m_r[3];
            4'd5: return m_r[4];
            4'd6: return m_r[5];
            4'd7: return m_r[6];
            4'd8: return m_r[7];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_r[i] = 32'h0;
        m_r[3] = 32'h0000_4000;
        m_r[4] = 32'h0000_3000;
        m_r[5] = 32'h0000_1000;
        m_mbr = 8'h0;
        m_dpend = 1'b0; m_dread = 1'b0; m_fpend = 1'b0;
        e_rd = 1'b0; e_wr = 1'b0; e_freq = 1'b0;
        e_addr = 32'h0; e_wdata = 32'h0; e_faddr = 32'h0;
    endtask

    task automatic model_update();
        logic [31:0] nr [0:8];
        logic st, di, fi;
        st = model_stall();
        for (int i = 0; i < 9; i++) nr[i] = (!st && c_en[i]) ? c_bus : m_r[i];
        if (mem_ack && m_dpend && m_dread) nr[1] = mem_rdata;
        if (fetch_valid && m_fpend) m_mbr = fetch_data;
        di = (mem_op[2] | mem_op[1]) && !st;
        fi = mem_op[0] && !st;
        e_rd = di && mem_op[1];
        e_wr = di && mem_op[2];
        e_freq = fi;
        if (di) begin
            m_dpend = 1'b1; m_dread = mem_op[1]; e_addr = nr[0]; e_wdata = nr[1];
        end else if (mem_ack) begin
            m_dpend = 1'b0;
        end
        if (fi) begin
            m_fpend = 1'b1; e_faddr = nr[2];
        end else if (fetch_valid) begin
            m_fpend = 1'b0;
        end
        for (int i = 0; i < 9; i++) m_r[i] = nr[i];
    endtask

    task automatic check_all();
        chk("stall", {31'h0, stall}, {31'h0, model_stall()});
        chk("b_bus", b_bus, model_b(b_sel));
        chk("h_out", h_out, m_r[8]);
        chk("mem_rd", {31'h0, mem_rd}, {31'h0, e_rd});
        chk("mem_wr", {31'h0, mem_wr}, {31'h0, e_wr});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("fetch_req", {31'h0, fetch_req}, {31'h0, e_freq});
        chk("fetch_addr", fetch_addr, e_faddr);
    endtask

    task automatic drive(input logic [31:0] cb, input logic [8:0] ce, input logic [3:0] bs,
                         input logic [2:0] op, input logic ack, input logic [31:0] rdat,
                         input logic fv, input logic [7:0] fd);
        @(negedge clk);
        c_bus = cb; c_en = ce; b_sel = bs; mem_op = op;
        mem_ack = ack; mem_rdata = rdat; fetch_valid = fv; fetch_data = fd;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic cyc(input logic [31:0] cb, input logic [8:0] ce, input logic [3:0] bs,
                       input logic [2:0] op, input logic ack, input logic [31:0] rdat,
                       input logic fv, input logic [7:0] fd);
        drive(cb, ce, bs, op, ack, rdat, fv, fd);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        c_bus = '0; c_en = '0; b_sel = '0; mem_op = '0;
        mem_ack = 1'b0; mem_rdata = '0; fetch_valid = 1'b0; fetch_data = '0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        c_bus = '0; c_en = '0; b_sel = '0; mem_op = '0;
        mem_ack = 1'b0; mem_rdata = '0; fetch_valid = 1'b0; fetch_data = '0;
        model_reset();

        // reset values
        do_reset();
        drive(32'h0, 9'h000, 4'd4, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("reset_sp", b_bus, 32'h0000_4000);
        tick();
        drive(32'h0, 9'h000, 4'd5, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("reset_lv", b_bus, 32'h0000_3000);
        tick();
        drive(32'h0, 9'h000, 4'd6, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("reset_cpp", b_bus, 32'h0000_1000);
        tick();

        // C write to H and OPC
        cyc(32'hDEAD_BEEF, 9'h180, 4'd7, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        drive(32'h0, 9'h000, 4'd8, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("cwr_h", h_out, 32'hDEAD_BEEF);
        chk("cwr_opc", b_bus, 32'hDEAD_BEEF);
        tick();
        drive(32'h0, 9'h000, 4'd7, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("cwr_tos_kept", b_bus, 32'h0);
        tick();

        // data read with same-cycle MAR write
        cyc(32'h10, 9'h001, 4'd0, 3'b010, 1'b0, 32'h0, 1'b0, 8'h0);
        drive(32'h0, 9'h000, 4'd0, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("rd_strobe", {31'h0, mem_rd}, 32'h1);
        chk("rd_addr", mem_addr, 32'h10);
        tick();
        cyc(32'h0, 9'h000, 4'd0, 3'b000, 1'b1, 32'h1234, 1'b0, 8'h0);
        drive(32'h0, 9'h000, 4'd0, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("rd_mdr", b_bus, 32'h1234);
        tick();

        // instruction fetch
        cyc(32'h5, 9'h004, 4'd1, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        cyc(32'h0, 9'h000, 4'd1, 3'b001, 1'b0, 32'h0, 1'b0, 8'h0);
        drive(32'h0, 9'h000, 4'd1, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("fetch_strobe", {31'h0, fetch_req}, 32'h1);
        chk("fetch_addr5", fetch_addr, 32'h5);
        tick();
        cyc(32'h0, 9'h000, 4'd1, 3'b000, 1'b0, 32'h0, 1'b1, 8'h9C);
        drive(32'h0, 9'h000, 4'd2, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("mbr_sx", b_bus, 32'hFFFF_FF9C);
        tick();
        drive(32'h0, 9'h000, 4'd3, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("mbr_zx", b_bus, 32'h0000_009C);
        tick();

        // stall on second read while first is outstanding
        cyc(32'h0, 9'h000, 4'd0, 3'b010, 1'b0, 32'h0, 1'b0, 8'h0);
        drive(32'hAAAA, 9'h100, 4'd0, 3'b010, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("stall_on", {31'h0, stall}, 32'h1);
        tick();
        drive(32'hAAAA, 9'h100, 4'd0, 3'b010, 1'b1, 32'h55, 1'b0, 8'h0);
        chk("stall_h_held", h_out, 32'hDEAD_BEEF);
        chk("stall_off", {31'h0, stall}, 32'h0);
        tick();
        drive(32'h0, 9'h000, 4'd0, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("stall_rd2", {31'h0, mem_rd}, 32'h1);
        chk("stall_h_wr", h_out, 32'h0000_AAAA);
        tick();
        cyc(32'h0, 9'h000, 4'd0, 3'b000, 1'b1, 32'h66, 1'b0, 8'h0);

        // memory data beats C write to MDR; reset drops pending read
        cyc(32'h0, 9'h000, 4'd0, 3'b010, 1'b0, 32'h0, 1'b0, 8'h0);
        cyc(32'h0, 9'h000, 4'd0, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        cyc(32'h9, 9'h002, 4'd0, 3'b000, 1'b1, 32'h7, 1'b0, 8'h0);
        drive(32'h0, 9'h000, 4'd0, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("ack_beats_c", b_bus, 32'h7);
        tick();
        cyc(32'h0, 9'h000, 4'd0, 3'b010, 1'b0, 32'h0, 1'b0, 8'h0);
        cyc(32'h0, 9'h000, 4'd0, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        do_reset();
        cyc(32'h0, 9'h000, 4'd0, 3'b000, 1'b1, 32'hBAD, 1'b0, 8'h0);
        drive(32'h0, 9'h000, 4'd0, 3'b000, 1'b0, 32'h0, 1'b0, 8'h0);
        chk("late_ack", b_bus, 32'h0);
        tick();

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            cyc($urandom, 9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
